nios_ram_dp: RTL
================

NIOS_RAM_DP -- requirements
Module: nios_ram_dp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data width in bits, which must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning word-address width; depth is 2**ADDR_W words.
REQ-003 SHALL have parameter READ_LATENCY, default 1, meaning cycles from read acceptance to readdatavalid; legal values are 1 and 2.
REQ-004 SHALL have parameter INIT_FILE, default "nios_RAM.hex", meaning the power-up content file.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 clken  in  1  global clock enable; low stalls the whole block.
REQ-008 reset_req  in  1  high behaves exactly like clken low.
REQ-009 sN_address  in  ADDR_W  word address, where N = 1, 2.
REQ-010 sN_byteenable  in  DATA_W/8  byte-lane enables for writes.
REQ-011 sN_chipselect, sN_read, sN_write  in  1 each  Avalon-MM command strobes.
REQ-012 sN_writedata  in  DATA_W  write data.
REQ-013 sN_readdata  out  DATA_W  read data.
REQ-014 sN_readdatavalid  out  1  readdata qualifier.
REQ-015 sN_waitrequest  out  1  command not accepted this cycle.

Function
REQ-016 A command SHALL be accepted on a rising clk edge when chipselect, (read or write), and not waitrequest are all true; read and write both high SHALL be treated as a write.
REQ-017 An accepted write SHALL update only the enabled byte lanes, visible to reads accepted from the next cycle onwards.
REQ-018 An accepted read SHALL return data with readdatavalid high exactly READ_LATENCY cycles after acceptance, with one result per cycle and no bubbles under back-to-back reads.
REQ-019 Read-during-write on the same address SHALL return old data, for both same-port and mixed-port cases.
REQ-020 When both ports issue a write to the same address in the same cycle, s1 SHALL be accepted and s2_waitrequest SHALL be high for that cycle; s2 is accepted on its retry.
REQ-021 Any other combination of simultaneous accesses on the two ports SHALL proceed with no waitrequest.
REQ-022 When clken is low or reset_req is high, both waitrequests SHALL be high, the read pipeline SHALL hold its state, readdatavalid SHALL be low, and no memory write SHALL occur.
REQ-023 waitrequest SHALL depend only on registered state, clken, reset_req and the collision compare, and never on readdata.
REQ-024 The outstanding-read pipeline depth SHALL be READ_LATENCY; no read SHALL be lost or duplicated across a stall.

Reset
REQ-025 While reset is high: readdatavalid=0, readdata=0, and both waitrequests=1 on both ports; the pipeline SHALL be flushed and in-flight reads discarded.
REQ-026 Memory content SHALL be preserved across reset, unless RAM_CLEAR_ON_RESET_EN is defined.
REQ-027 With the clear feature compiled out, waitrequests SHALL drop in the first cycle after reset deasserts.

Configuration
REQ-028 Macro RAM_CLEAR_ON_RESET_EN, when defined, SHALL add a clear engine with states IDLE and CLEAR.
REQ-029 Reset SHALL force state CLEAR with the counter at 0.
REQ-030 In CLEAR, the engine SHALL write zero to the counter address each enabled cycle, incrementing the counter; after address 2**ADDR_W-1 it SHALL go to IDLE; both waitrequests SHALL stay high throughout CLEAR.
REQ-031 In CLEAR, clken low or reset_req high SHALL pause the counter; reset asserted mid-clear SHALL restart the clear from 0.
REQ-032 When RAM_CLEAR_ON_RESET_EN is undefined, no clear logic SHALL exist and behaviour SHALL follow REQ-026 and REQ-027.

Verification
REQ-033 Write 0xDEADBEEF to address 5 with byteenable 0xF, then write 0x000000AA with byteenable 0x1, then read address 5 -> readdata 0xDEADBEAA at the READ_LATENCY cycle.
REQ-034 Issue back-to-back reads of addresses 0..7 on s1 with READ_LATENCY=2 -> 8 consecutive readdatavalid pulses, in order, starting 2 cycles after the first read.
REQ-035 Write s1=0x11111111 and s2=0x22222222 to address 3 in the same cycle -> s2_waitrequest high for 1 cycle, s2 retries, and a later read of address 3 returns 0x22222222.
REQ-036 Drop clken for 3 cycles with 2 reads in flight -> no readdatavalid during the stall; both results are delivered in order after clken returns.
REQ-037 With RAM_CLEAR_ON_RESET_EN and ADDR_W=4, pulse reset -> waitrequest high for 16 enabled cycles, then a read of any address returns 0.
REQ-038 Without the macro, write address 9, pulse reset, then read address 9 -> the written value is returned and waitrequest is low on the first cycle after reset.

Source files
------------

// File: rtl/nios_ram_dp.sv
// -----------------------------------------------------------------------------
// nios_ram_dp
// True dual-port on-chip RAM with two Avalon-MM slave ports (s1, s2) sharing a
// single clock. Reads are pipelined (READ_LATENCY = 1 or 2) with readdatavalid.
// Writes honour byte enables. A same-address write/write collision gives s1
// priority and holds s2 off for one cycle with waitrequest.
//
// Handshake: a command is taken on a rising clk edge when
// chipselect & (read | write) & ~waitrequest. read and write together count as
// a write. readdatavalid qualifies readdata and is never backpressured.
//
// Parameters:
//   DATA_W       data width in bits (multiple of 8)
//   ADDR_W       word address width, depth = 2**ADDR_W
//   READ_LATENCY cycles from read acceptance to readdatavalid (1 or 2)
//   INIT_FILE    power-up content file (must not be empty). It is consumed by
//                the device programming flow; memory content is not reset.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   clken, reset_req       clock enable / request to hold; either stalls all
//   sN_address/byteenable/chipselect/read/write/writedata   slave N command
//   sN_readdata/readdatavalid/waitrequest                   slave N response
//
// Build option: define RAM_CLEAR_ON_RESET_EN to add a clear engine that zeroes
// every word after reset (states IDLE/CLEAR, ports held in waitrequest while
// clearing).
// -----------------------------------------------------------------------------
module nios_ram_dp #(
   parameter int    DATA_W       = 32,
   parameter int    ADDR_W       = 10,
   parameter int    READ_LATENCY = 1,
   parameter string INIT_FILE    = "nios_RAM.hex"
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clken,
   input  logic                reset_req,
   input  logic [ADDR_W-1:0]   s1_address,
   input  logic [DATA_W/8-1:0] s1_byteenable,
   input  logic                s1_chipselect,
   input  logic                s1_read,
   input  logic                s1_write,
   input  logic [DATA_W-1:0]   s1_writedata,
   output logic [DATA_W-1:0]   s1_readdata,
   output logic                s1_readdatavalid,
   output logic                s1_waitrequest,
   input  logic [ADDR_W-1:0]   s2_address,
   input  logic [DATA_W/8-1:0] s2_byteenable,
   input  logic                s2_chipselect,
   input  logic                s2_read,
   input  logic                s2_write,
   input  logic [DATA_W-1:0]   s2_writedata,
   output logic [DATA_W-1:0]   s2_readdata,
   output logic                s2_readdatavalid,
   output logic                s2_waitrequest
);

   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 1 << ADDR_W;
   localparam bit TWO_STAGE = (READ_LATENCY == 2);

   if ((DATA_W % 8) != 0 || (READ_LATENCY != 1 && READ_LATENCY != 2) ||
       INIT_FILE == "") begin : g_bad_param
      $error("nios_ram_dp: illegal parameter combination");
   end

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic en;
   logic busy;
   logic stall;
   logic collide;
   logic wr1_acc, wr2_acc;
   logic [1:0] rd_acc;
   logic [ADDR_W-1:0] rd_addr [2];

   assign en = clken & ~reset_req;

`ifdef RAM_CLEAR_ON_RESET_EN
   typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_e;
   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              clr_we;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_we  = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            // The counter only advances on enabled cycles, so a stall pauses
            // the sweep without skipping any address.
            if (en) begin
               clr_we = 1'b1;
               cnt_d  = cnt_q + 1'b1;
               if (&cnt_q) state_d = ST_IDLE;
            end
         end
         default: ;
      endcase
   end

   assign busy = (state_q == ST_CLEAR);
`else
   assign busy = 1'b0;
`endif

   // waitrequest is built only from reset, enables, clear state and the
   // address compare, never from the read datapath.
   assign stall   = reset | ~en | busy;
   assign collide = s1_chipselect & s1_write & s2_chipselect & s2_write &
                    (s1_address == s2_address);

   assign s1_waitrequest = stall;
   assign s2_waitrequest = stall | collide;

   assign wr1_acc   = s1_chipselect & s1_write & ~s1_waitrequest;
   assign wr2_acc   = s2_chipselect & s2_write & ~s2_waitrequest;
   assign rd_acc[0] = s1_chipselect & s1_read & ~s1_write & ~s1_waitrequest;
   assign rd_acc[1] = s2_chipselect & s2_read & ~s2_write & ~s2_waitrequest;
   assign rd_addr[0] = s1_address;
   assign rd_addr[1] = s2_address;

   // Memory array: no reset, so content survives reset unless cleared.
   always_ff @(posedge clk) begin
`ifdef RAM_CLEAR_ON_RESET_EN
      if (clr_we) mem_q[cnt_q] <= '0;
`endif
      for (int b = 0; b < NB; b++) begin
         if (wr1_acc && s1_byteenable[b]) mem_q[s1_address][b*8 +: 8] <= s1_writedata[b*8 +: 8];
         if (wr2_acc && s2_byteenable[b]) mem_q[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
      end
   end

   // Read pipeline. Stage 1 samples the array on the same edge that writes it,
   // so a read-during-write returns the old word. The whole pipeline freezes
   // while disabled, which keeps in-flight reads intact across a stall.
   logic [1:0]        v1_q, v2_q;
   logic [DATA_W-1:0] d1_q [2];
   logic [DATA_W-1:0] d2_q [2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1_q <= '0;
         v2_q <= '0;
         for (int p = 0; p < 2; p++) begin
            d1_q[p] <= '0;
            d2_q[p] <= '0;
         end
      end else if (en) begin
         for (int p = 0; p < 2; p++) begin
            v1_q[p] <= rd_acc[p];
            if (rd_acc[p]) d1_q[p] <= mem_q[rd_addr[p]];
            v2_q[p] <= v1_q[p];
            d2_q[p] <= d1_q[p];
         end
      end
   end

   logic [1:0] v_out;
   assign v_out = TWO_STAGE ? v2_q : v1_q;

   // Results are only presented on enabled cycles; a held result reappears
   // once the enable returns and is consumed on that edge.
   assign s1_readdatavalid = v_out[0] & en;
   assign s2_readdatavalid = v_out[1] & en;
   assign s1_readdata      = TWO_STAGE ? d2_q[0] : d1_q[0];
   assign s2_readdata      = TWO_STAGE ? d2_q[1] : d1_q[1];

endmodule
